mips32_control: RTL and testbench
=================================

Name: mips32_control

Overview:
Multicycle control unit that fetches instruction words over a valid/ready handshake and decodes them. It sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, drives every control and operand-address input of the mips32 datapath slice, and consumes that slice's branch_result. It owns the program counter.

Parameters:
RESET_PC, 32'h0000_0000, pc value loaded on reset

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high
instr  input  32  instruction word from instruction memory
instr_valid  input  1  instr holds a valid word for the current pc
instr_ready  output  1  controller accepts instr this cycle (FETCH state only)
pc  output  32  address of the instruction being fetched/executed
branch_result  input  1  datapath ALU sign bit (alu_out[31])
rsaddr  output  5  instr[25:21]
rtaddr  output  5  instr[20:16]
rt_rd_chosen  output  5  write-back register: rd (instr[15:11]) for R-type, rt for I-type
shiftImm  output  32  zero-extended shamt instr[10:6]
S_ZextendImm  output  32  sign- or zero-extended instr[15:0] per opcode
shift_select  output  1  1 = ALU left=rt, right=shiftImm (sll/srl)
slt_select  output  1  1 = result is zero-extended ALU sign bit
alubits  output  3  ALU op: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLL, 110 SUB, 111 SRL
immediate_res  output  1  1 = ALU right operand is S_ZextendImm
reg_write  output  1  register-file write strobe, one cycle
memread  output  1  data-memory read enable
memwrite  output  1  data-memory write strobe, one cycle
alu_mem  output  1  1 = write-back value from memory
illegal  output  1  one-cycle pulse on undecodable instruction

Behaviour:
- Reset (sampled high on an edge): pc=RESET_PC; state=FETCH; all control outputs, illegal and the latched instruction = 0. instr_ready is 0 while reset is high.
- Reset mid-instruction aborts it: no reg_write or memwrite pulse follows.
- FETCH: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to DECODE; otherwise stay.
- DECODE (1 cycle): all controls are registered from the latched word and stay stable through EXECUTE..WRITEBACK. Go to EXECUTE.
- Decode table:
  - R-type op 0: funct 20 add (010), 22 sub (110), 24 and (000), 25 or (001), 26 xor (011), 27 nor (100), 2A slt (110, slt_select=1), 00 sll (101, shift_select=1), 02 srl (111, shift_select=1).
  - I-type: 08 addi (010, sign-ext), 0A slti (110, sign-ext, slt_select=1), 0C andi (000, zero-ext), 0D ori (001, zero-ext). All I-type set immediate_res=1.
  - Memory: 23 lw and 2B sw (010, sign-ext, immediate_res=1).
  - Branch: op 01 with rt=0 is bltz; rt=1 is bgez. Both drive alubits=110, immediate_res=0, rtaddr=0 so the ALU computes rs-$0.
- EXECUTE (1 cycle): ALU-class goes to WRITEBACK; lw/sw go to MEMORY.
- Branch in EXECUTE: sample branch_result at end of cycle. Taken when bltz&&branch_result or bgez&&!branch_result. Then pc <= pc+4+(sext(imm)<<2) if taken, else pc+4, and return to FETCH.
- MEMORY: lw holds memread=1 and alu_mem=1, then goes to WRITEBACK. sw asserts memwrite=1 for exactly this cycle, then pc+=4 and FETCH.
- WRITEBACK: reg_write=1 for exactly this cycle; pc+=4; FETCH. memread stays 1 for lw.
- Latency from accept edge back to FETCH:
  - branch: 2 cycles
  - ALU and sw: 3 cycles
  - lw: 4 cycles
- Illegal opcode/funct: illegal pulses 1 cycle in DECODE; no reg_write or memwrite; pc+=4; FETCH.
- reg_write, memwrite and memread are 0 in FETCH and DECODE, and memwrite is never asserted with reg_write.
- pc arithmetic is modulo 2^32, so 32'hFFFF_FFFC+4 = 0. A branch offset wraps the same way.
- instr is ignored outside FETCH. instr_valid held high across non-FETCH cycles does not double-accept.

Test Plan:
- Reset then instr_valid=1, instr=0x012A4020 (add $8,$9,$10) -> accept at cycle 1; rsaddr=9, rtaddr=10, rt_rd_chosen=8, alubits=010; reg_write single pulse 3 cycles after accept; pc=4.
- lw $2,-4($3) (0x8C62FFFC) -> S_ZextendImm=0xFFFFFFFC, immediate_res=1; memread and alu_mem high from MEMORY through WRITEBACK; reg_write one cycle.
- bltz $5,+3 with branch_result=1 at pc=0x10 -> pc=0x20, no reg_write. Repeat with branch_result=0 -> pc=0x14. bgez has the inverse outcomes.
- sll $4,$6,7 (0x000621C0) -> shift_select=1, shiftImm=7, alubits=101. ori with imm 0x8000 -> S_ZextendImm=0x00008000.
- Opcode 0x3F -> illegal one pulse, no writes, pc+4. instr_valid low for 5 cycles in FETCH -> pc and controls frozen.
- Reset asserted during MEMORY of sw -> no memwrite pulse; next cycle pc=RESET_PC, all outputs 0. Also check pc=0xFFFFFFFC wraps to 0.

Source files
------------

// File: rtl/mips32_control_if.sv
// Fetch handshake and datapath control bundle between the mips32 controller and
// its instruction memory / datapath slice.
interface mips32_control_if;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc;
  logic        branch_result;
  logic [4:0]  rsaddr;
  logic [4:0]  rtaddr;
  logic [4:0]  rt_rd_chosen;
  logic [31:0] shiftImm;
  logic [31:0] S_ZextendImm;
  logic        shift_select;
  logic        slt_select;
  logic [2:0]  alubits;
  logic        immediate_res;
  logic        reg_write;
  logic        memread;
  logic        memwrite;
  logic        alu_mem;
  logic        illegal;

  // Controller side.
  modport master (
    input  instr, instr_valid, branch_result,
    output instr_ready, pc, rsaddr, rtaddr, rt_rd_chosen, shiftImm, S_ZextendImm,
           shift_select, slt_select, alubits, immediate_res, reg_write, memread,
           memwrite, alu_mem, illegal
  );

  // Instruction memory / datapath side.
  modport slave (
    output instr, instr_valid, branch_result,
    input  instr_ready, pc, rsaddr, rtaddr, rt_rd_chosen, shiftImm, S_ZextendImm,
           shift_select, slt_select, alubits, immediate_res, reg_write, memread,
           memwrite, alu_mem, illegal
  );
endinterface

// File: rtl/mips32_control.sv
// Multicycle MIPS32 control unit: fetches over valid/ready, decodes, sequences
// FETCH..WRITEBACK and owns the program counter.
module mips32_control #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clock,
  input  logic             reset,
  mips32_control_if.master bus
);

  typedef enum logic [2:0] {StFetch, StDecode, StExecute, StMemory, StWriteback} state_e;
  typedef enum logic [2:0] {ClsAlu, ClsLoad, ClsStore, ClsBltz, ClsBgez, ClsIllegal} cls_e;

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d;
  logic [31:0] pc_q, pc_d;
  logic [4:0]  rsaddr_q, rsaddr_d;
  logic [4:0]  rtaddr_q, rtaddr_d;
  logic [4:0]  rt_rd_q, rt_rd_d;
  logic [4:0]  shamt_q, shamt_d;
  logic [31:0] simm_q, simm_d;
  logic        shift_sel_q, shift_sel_d;
  logic        slt_sel_q, slt_sel_d;
  logic        imm_res_q, imm_res_d;
  logic [2:0]  alubits_q, alubits_d;
  logic        reg_write_q, reg_write_d;
  logic        memread_q, memread_d;
  logic        memwrite_q, memwrite_d;
  logic        alu_mem_q, alu_mem_d;
  logic        illegal_q, illegal_d;

  // Decode of the word presented on the fetch bus.
  cls_e        dec_cls;
  logic [4:0]  dec_rtaddr;
  logic [4:0]  dec_rt_rd;
  logic [31:0] dec_simm;
  logic        dec_shift_sel;
  logic        dec_slt_sel;
  logic        dec_imm_res;
  logic        dec_zext;
  logic [2:0]  dec_alubits;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [15:0] imm16;

  assign op    = bus.instr[31:26];
  assign funct = bus.instr[5:0];
  assign imm16 = bus.instr[15:0];

  always_comb begin
    dec_cls       = ClsIllegal;
    dec_rtaddr    = bus.instr[20:16];
    dec_rt_rd     = bus.instr[20:16];
    dec_shift_sel = 1'b0;
    dec_slt_sel   = 1'b0;
    dec_imm_res   = 1'b0;
    dec_zext      = 1'b0;
    dec_alubits   = 3'b000;
    unique case (op)
      6'h00: begin
        dec_cls   = ClsAlu;
        dec_rt_rd = bus.instr[15:11];
        unique case (funct)
          6'h20: dec_alubits = 3'b010;
          6'h22: dec_alubits = 3'b110;
          6'h24: dec_alubits = 3'b000;
          6'h25: dec_alubits = 3'b001;
          6'h26: dec_alubits = 3'b011;
          6'h27: dec_alubits = 3'b100;
          6'h2A: begin
            dec_alubits = 3'b110;
            dec_slt_sel = 1'b1;
          end
          6'h00: begin
            dec_alubits   = 3'b101;
            dec_shift_sel = 1'b1;
          end
          6'h02: begin
            dec_alubits   = 3'b111;
            dec_shift_sel = 1'b1;
          end
          default: dec_cls = ClsIllegal;
        endcase
      end
      6'h08: begin
        dec_cls     = ClsAlu;
        dec_alubits = 3'b010;
        dec_imm_res = 1'b1;
      end
      6'h0A: begin
        dec_cls     = ClsAlu;
        dec_alubits = 3'b110;
        dec_slt_sel = 1'b1;
        dec_imm_res = 1'b1;
      end
      6'h0C: begin
        dec_cls     = ClsAlu;
        dec_alubits = 3'b000;
        dec_imm_res = 1'b1;
        dec_zext    = 1'b1;
      end
      6'h0D: begin
        dec_cls     = ClsAlu;
        dec_alubits = 3'b001;
        dec_imm_res = 1'b1;
        dec_zext    = 1'b1;
      end
      6'h23: begin
        dec_cls     = ClsLoad;
        dec_alubits = 3'b010;
        dec_imm_res = 1'b1;
      end
      6'h2B: begin
        dec_cls     = ClsStore;
        dec_alubits = 3'b010;
        dec_imm_res = 1'b1;
      end
      6'h01: begin
        // rs - $0 leaves rs's sign in alu_out[31].
        dec_rtaddr  = 5'd0;
        dec_alubits = 3'b110;
        if (bus.instr[20:16] == 5'd0) begin
          dec_cls = ClsBltz;
        end else if (bus.instr[20:16] == 5'd1) begin
          dec_cls = ClsBgez;
        end else begin
          dec_cls = ClsIllegal;
        end
      end
      default: dec_cls = ClsIllegal;
    endcase
    // Undecodable words leave the datapath idle.
    if (dec_cls == ClsIllegal) begin
      dec_shift_sel = 1'b0;
      dec_slt_sel   = 1'b0;
      dec_imm_res   = 1'b0;
      dec_alubits   = 3'b000;
    end
    dec_simm = dec_zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
  end

  logic        accept;
  logic        br_taken;
  logic [31:0] pc_plus4;

  assign accept   = (state_q == StFetch) && bus.instr_valid;
  assign pc_plus4 = pc_q + 32'd4;
  assign br_taken = ((cls_q == ClsBltz) && bus.branch_result) ||
                    ((cls_q == ClsBgez) && !bus.branch_result);

  always_comb begin
    state_d     = state_q;
    cls_d       = cls_q;
    pc_d        = pc_q;
    rsaddr_d    = rsaddr_q;
    rtaddr_d    = rtaddr_q;
    rt_rd_d     = rt_rd_q;
    shamt_d     = shamt_q;
    simm_d      = simm_q;
    shift_sel_d = shift_sel_q;
    slt_sel_d   = slt_sel_q;
    imm_res_d   = imm_res_q;
    alubits_d   = alubits_q;
    reg_write_d = 1'b0;
    memread_d   = 1'b0;
    memwrite_d  = 1'b0;
    alu_mem_d   = 1'b0;
    illegal_d   = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (accept) begin
          state_d     = StDecode;
          cls_d       = dec_cls;
          rsaddr_d    = bus.instr[25:21];
          rtaddr_d    = dec_rtaddr;
          rt_rd_d     = dec_rt_rd;
          shamt_d     = bus.instr[10:6];
          simm_d      = dec_simm;
          shift_sel_d = dec_shift_sel;
          slt_sel_d   = dec_slt_sel;
          imm_res_d   = dec_imm_res;
          alubits_d   = dec_alubits;
          illegal_d   = (dec_cls == ClsIllegal);
        end
      end
      StDecode: begin
        if (cls_q == ClsIllegal) begin
          pc_d    = pc_plus4;
          state_d = StFetch;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: begin
        unique case (cls_q)
          ClsAlu: begin
            state_d     = StWriteback;
            reg_write_d = 1'b1;
          end
          ClsLoad: begin
            state_d   = StMemory;
            memread_d = 1'b1;
            alu_mem_d = 1'b1;
          end
          ClsStore: begin
            state_d    = StMemory;
            memwrite_d = 1'b1;
          end
          ClsBltz, ClsBgez: begin
            pc_d    = br_taken ? pc_plus4 + {simm_q[29:0], 2'b00} : pc_plus4;
            state_d = StFetch;
          end
          default: state_d = StFetch;
        endcase
      end
      StMemory: begin
        if (cls_q == ClsLoad) begin
          state_d     = StWriteback;
          reg_write_d = 1'b1;
          memread_d   = 1'b1;
          alu_mem_d   = 1'b1;
        end else begin
          pc_d    = pc_plus4;
          state_d = StFetch;
        end
      end
      StWriteback: begin
        pc_d    = pc_plus4;
        state_d = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StFetch;
      cls_q       <= ClsAlu;
      pc_q        <= RESET_PC;
      rsaddr_q    <= '0;
      rtaddr_q    <= '0;
      rt_rd_q     <= '0;
      shamt_q     <= '0;
      simm_q      <= '0;
      shift_sel_q <= 1'b0;
      slt_sel_q   <= 1'b0;
      imm_res_q   <= 1'b0;
      alubits_q   <= '0;
      reg_write_q <= 1'b0;
      memread_q   <= 1'b0;
      memwrite_q  <= 1'b0;
      alu_mem_q   <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cls_q       <= cls_d;
      pc_q        <= pc_d;
      rsaddr_q    <= rsaddr_d;
      rtaddr_q    <= rtaddr_d;
      rt_rd_q     <= rt_rd_d;
      shamt_q     <= shamt_d;
      simm_q      <= simm_d;
      shift_sel_q <= shift_sel_d;
      slt_sel_q   <= slt_sel_d;
      imm_res_q   <= imm_res_d;
      alubits_q   <= alubits_d;
      reg_write_q <= reg_write_d;
      memread_q   <= memread_d;
      memwrite_q  <= memwrite_d;
      alu_mem_q   <= alu_mem_d;
      illegal_q   <= illegal_d;
    end
  end

  // Write strobes are masked by reset so an aborted instruction never commits.
  assign bus.instr_ready   = (state_q == StFetch) && !reset;
  assign bus.reg_write     = reg_write_q && !reset;
  assign bus.memwrite      = memwrite_q && !reset;
  assign bus.pc            = pc_q;
  assign bus.rsaddr        = rsaddr_q;
  assign bus.rtaddr        = rtaddr_q;
  assign bus.rt_rd_chosen  = rt_rd_q;
  assign bus.shiftImm      = {27'd0, shamt_q};
  assign bus.S_ZextendImm  = simm_q;
  assign bus.shift_select  = shift_sel_q;
  assign bus.slt_select    = slt_sel_q;
  assign bus.alubits       = alubits_q;
  assign bus.immediate_res = imm_res_q;
  assign bus.memread       = memread_q;
  assign bus.alu_mem       = alu_mem_q;
  assign bus.illegal       = illegal_q;

endmodule

// File: tb/tb_mips32_control.sv
// Randomized self-checking bench for mips32_control against an instruction-level
// reference model (per-instruction cycle budget, strobes and pc outcome).
module tb_mips32_control;

  localparam int ClsAlu = 0;
  localparam int ClsLw  = 1;
  localparam int ClsSw  = 2;
  localparam int ClsLtz = 3;
  localparam int ClsGez = 4;
  localparam int ClsIll = 5;

  typedef struct {
    int          cls;
    logic [2:0]  alu;
    logic        sh;
    logic        slt;
    logic        imr;
    logic [31:0] simm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dst;
    logic [31:0] shimm;
  } exp_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;
  logic [31:0] model_pc;
  logic [2:0]  last_alu;

  mips32_control_if bus ();

  mips32_control #(.RESET_PC(32'h0000_0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction-level reference decode.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    logic [5:0] op;
    logic [5:0] fn;
    op      = w[31:26];
    fn      = w[5:0];
    e.cls   = ClsIll;
    e.alu   = 3'b000;
    e.sh    = 1'b0;
    e.slt   = 1'b0;
    e.imr   = 1'b0;
    e.rs    = w[25:21];
    e.rt    = w[20:16];
    e.dst   = w[20:16];
    e.shimm = 32'(w[10:6]);
    e.simm  = 32'(signed'(w[15:0]));
    if (op == 6'h00) begin
      e.dst = w[15:11];
      e.cls = ClsAlu;
      case (fn)
        6'h20: e.alu = 3'b010;
        6'h22: e.alu = 3'b110;
        6'h24: e.alu = 3'b000;
        6'h25: e.alu = 3'b001;
        6'h26: e.alu = 3'b011;
        6'h27: e.alu = 3'b100;
        6'h2A: begin e.alu = 3'b110; e.slt = 1'b1; end
        6'h00: begin e.alu = 3'b101; e.sh = 1'b1; end
        6'h02: begin e.alu = 3'b111; e.sh = 1'b1; end
        default: e.cls = ClsIll;
      endcase
    end else if (op == 6'h08 || op == 6'h0A || op == 6'h0C || op == 6'h0D) begin
      e.cls = ClsAlu;
      e.imr = 1'b1;
      e.alu = (op == 6'h08) ? 3'b010 : (op == 6'h0A) ? 3'b110 : (op == 6'h0C) ? 3'b000 : 3'b001;
      e.slt = (op == 6'h0A);
      if (op == 6'h0C || op == 6'h0D) e.simm = {16'h0, w[15:0]};
    end else if (op == 6'h23 || op == 6'h2B) begin
      e.cls = (op == 6'h23) ? ClsLw : ClsSw;
      e.imr = 1'b1;
      e.alu = 3'b010;
    end else if (op == 6'h01 && w[20:17] == 4'd0) begin
      e.cls = w[16] ? ClsGez : ClsLtz;
      e.alu = 3'b110;
      e.rt  = 5'd0;
    end
    return e;
  endfunction

  function automatic int ref_cycles(input int cls);
    case (cls)
      ClsIll:         return 1;
      ClsLtz, ClsGez: return 2;
      ClsLw:          return 4;
      default:        return 3;
    endcase
  endfunction

  // Present one word, follow it cycle by cycle and check the pc it leaves behind.
  task automatic run_instr(input logic [31:0] w, input logic br);
    exp_t        e;
    int          n;
    logic [31:0] pc0;
    bit          taken;
    e   = ref_decode(w);
    n   = ref_cycles(e.cls);
    pc0 = model_pc;
    check_eq("ready_fetch", 32'(bus.instr_ready), 32'd1);
    check_eq("pc_fetch", bus.pc, pc0);
    bus.instr         = w;
    bus.instr_valid   = 1'b1;
    bus.branch_result = br;
    @(posedge clock); #1;
    for (int k = 1; k <= n; k++) begin
      bus.instr       = $urandom;
      bus.instr_valid = 1'($urandom_range(0, 1));
      check_eq("reg_write", 32'(bus.reg_write),
               32'((e.cls == ClsAlu && k == 3) || (e.cls == ClsLw && k == 4)));
      check_eq("memwrite", 32'(bus.memwrite), 32'(e.cls == ClsSw && k == 3));
      check_eq("memread", 32'(bus.memread), 32'(e.cls == ClsLw && k >= 3));
      check_eq("alu_mem", 32'(bus.alu_mem), 32'(e.cls == ClsLw && k >= 3));
      check_eq("illegal", 32'(bus.illegal), 32'(e.cls == ClsIll && k == 1));
      check_eq("ready_busy", 32'(bus.instr_ready), 32'd0);
      check_eq("pc_hold", bus.pc, pc0);
      if (e.cls != ClsIll) begin
        check_eq("alubits", 32'(bus.alubits), 32'(e.alu));
        check_eq("imm_res", 32'(bus.immediate_res), 32'(e.imr));
        if (k == 1) begin
          check_eq("rsaddr", 32'(bus.rsaddr), 32'(e.rs));
          check_eq("rtaddr", 32'(bus.rtaddr), 32'(e.rt));
          check_eq("shift_sel", 32'(bus.shift_select), 32'(e.sh));
          check_eq("slt_sel", 32'(bus.slt_select), 32'(e.slt));
          check_eq("shiftImm", bus.shiftImm, e.shimm);
          if (e.cls == ClsAlu || e.cls == ClsLw)
            check_eq("rt_rd", 32'(bus.rt_rd_chosen), 32'(e.dst));
          if (w[31:26] != 6'h00) check_eq("s_zext_imm", bus.S_ZextendImm, e.simm);
        end
      end
      @(posedge clock); #1;
    end
    bus.instr_valid = 1'b0;
    taken = (e.cls == ClsLtz && br) || (e.cls == ClsGez && !br);
    model_pc = pc0 + 32'd4 + (taken ? (e.simm << 2) : 32'd0);
    if (e.cls != ClsIll) last_alu = e.alu;
    check_eq("pc_next", bus.pc, model_pc);
    check_eq("ready_back", 32'(bus.instr_ready), 32'd1);
    check_eq("no_wr_fetch", 32'({bus.reg_write, bus.memwrite, bus.memread}), 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0]  rfn [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h00, 6'h02};
    logic [5:0]  iop [4] = '{6'h08, 6'h0A, 6'h0C, 6'h0D};
    logic [5:0]  bad [5] = '{6'h02, 6'h04, 6'h10, 6'h3F, 6'h20};
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 6))
      0, 1: return {6'h00, r[25:6], rfn[$urandom_range(0, 8)]};
      2:    return {iop[$urandom_range(0, 3)], r[25:0]};
      3:    return {6'h23, r[25:0]};
      4:    return {6'h2B, r[25:0]};
      5:    return {6'h01, r[25:21], 4'd0, r[16], r[15:0]};
      default: begin
        case ($urandom_range(0, 2))
          0:       return {bad[$urandom_range(0, 4)], r[25:0]};
          1:       return {6'h00, r[25:6], 6'h3F};
          default: return {6'h01, r[25:21], 5'd5, r[15:0]};
        endcase
      end
    endcase
  endfunction

  initial begin
    n_checks          = 0;
    n_fail            = 0;
    last_alu          = 3'b000;
    reset             = 1'b1;
    bus.instr         = 32'h0;
    bus.instr_valid   = 1'b0;
    bus.branch_result = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_ready", 32'(bus.instr_ready), 32'd0);
    check_eq("rst_pc", bus.pc, 32'h0);
    check_eq("rst_ctrl", 32'({bus.reg_write, bus.memwrite, bus.memread, bus.alu_mem,
                              bus.illegal, bus.alubits}), 32'd0);
    check_eq("rst_imm", bus.S_ZextendImm, 32'h0);
    reset    = 1'b0;
    model_pc = 32'h0;
    #1;

    run_instr(32'h012A_4020, 1'b0);  // add $8,$9,$10
    run_instr(32'h8C62_FFFC, 1'b0);  // lw $2,-4($3)
    run_instr(32'h012A_4022, 1'b0);
    run_instr(32'h012A_4024, 1'b0);
    run_instr(32'h04A0_0003, 1'b1);  // bltz taken
    run_instr(32'h04A0_0003, 1'b0);  // bltz not taken
    run_instr(32'h04A1_0003, 1'b0);  // bgez taken
    run_instr(32'h04A1_0003, 1'b1);  // bgez not taken
    run_instr(32'hFC00_0000, 1'b0);  // illegal opcode
    run_instr(32'h0006_21C0, 1'b0);  // sll $4,$6,7
    run_instr(32'h3422_8000, 1'b0);  // ori $2,$1,0x8000

    // Starved fetch: nothing moves.
    for (int i = 0; i < 5; i++) begin
      bus.instr = $urandom;
      @(posedge clock); #1;
      check_eq("idle_pc", bus.pc, model_pc);
      check_eq("idle_alu", 32'(bus.alubits), 32'(last_alu));
      check_eq("idle_ready", 32'(bus.instr_ready), 32'd1);
      check_eq("idle_wr", 32'({bus.reg_write, bus.memwrite, bus.illegal}), 32'd0);
    end

    // Reset during MEMORY of sw aborts the store.
    bus.instr       = 32'hAC62_0008;
    bus.instr_valid = 1'b1;
    @(posedge clock); #1;
    bus.instr_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check_eq("sw_mem_wr", 32'(bus.memwrite), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("abort_memwrite", 32'(bus.memwrite), 32'd0);
    @(posedge clock); #1;
    check_eq("abort_pc", bus.pc, 32'h0);
    check_eq("abort_ctrl", 32'({bus.reg_write, bus.memwrite, bus.memread, bus.alu_mem,
                                bus.illegal, bus.alubits, bus.immediate_res}), 32'd0);
    check_eq("abort_imm", bus.S_ZextendImm, 32'h0);
    reset    = 1'b0;
    model_pc = 32'h0;
    #1;

    run_instr(32'h0401_FFFE, 1'b0);  // bgez $0,-2 from 0 lands on 0xFFFFFFFC
    check_eq("wrap_target", bus.pc, 32'hFFFF_FFFC);
    run_instr(32'h012A_4020, 1'b0);
    check_eq("wrap_pc", bus.pc, 32'h0);

    for (int i = 0; i < 80; i++) begin
      run_instr(rand_instr(), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
